// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32 x XLEN RISC-V integer register file with debug read port
//
// Purpose:
//   Register file for the single-cycle core. x0 is hardwired to zero and not
//   stored; x2 (sp) and x3 (gp) reset to SP_INIT / GP_INIT, all others to 0.
//   Two operand read ports and one debug read port, all combinational.
//   A 32-bit counter tracks committed (non-x0) writes and wraps to 0.
//
// Optional feature:
//   REGFILE_BYPASS_EN - when defined, readData1/readData2 forward writeData
//   in the same cycle as a matching write. dbgData is never forwarded.
//   Leave undefined for the single-cycle core (ALU -> writeback -> bypass
//   would form a combinational loop).
//
// Ports:
//   clk        in   1     system clock, rising edge
//   rst        in   1     synchronous reset, active-high
//   regWrite   in   1     write enable
//   writeReg   in   5     destination index (rd)
//   writeData  in   XLEN  writeback value
//   readReg1   in   5     rs1 index
//   readReg2   in   5     rs2 index
//   readData1  out  XLEN  rs1 value
//   readData2  out  XLEN  rs2 value
//   dbgReg     in   5     debug read index
//   dbgData    out  XLEN  debug read value (never forwarded)
//   wrCount    out  32    committed write count

module reg_file #(
    parameter int              XLEN    = 32,
    parameter logic [XLEN-1:0] SP_INIT = 32'h0000_3FFC,
    parameter logic [XLEN-1:0] GP_INIT = 32'h0000_1800
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWrite,
    input  logic [4:0]      writeReg,
    input  logic [XLEN-1:0] writeData,
    input  logic [4:0]      readReg1,
    input  logic [4:0]      readReg2,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    input  logic [4:0]      dbgReg,
    output logic [XLEN-1:0] dbgData,
    output logic [31:0]     wrCount
);

    // x1..x31 only; index 0 has no storage.
    logic [XLEN-1:0] r_regs [1:31];
    logic [31:0]     r_wr_count;

    // A write commits only outside reset and never to x0.
    logic            w_wr_en;
    logic [XLEN-1:0] w_rd1_stored;
    logic [XLEN-1:0] w_rd2_stored;

    assign w_wr_en = regWrite && !rst && (writeReg != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < 32; i++) begin
                if (i == 2) begin
                    r_regs[i] <= SP_INIT;
                end else if (i == 3) begin
                    r_regs[i] <= GP_INIT;
                end else begin
                    r_regs[i] <= '0;
                end
            end
            r_wr_count <= '0;
        end else if (w_wr_en) begin
            r_regs[writeReg] <= writeData;
            r_wr_count       <= r_wr_count + 32'd1;
        end
    end

    always_comb begin
        w_rd1_stored = '0;
        w_rd2_stored = '0;
        dbgData      = '0;
        if (readReg1 != 5'd0) w_rd1_stored = r_regs[readReg1];
        if (readReg2 != 5'd0) w_rd2_stored = r_regs[readReg2];
        if (dbgReg   != 5'd0) dbgData      = r_regs[dbgReg];
    end

`ifdef REGFILE_BYPASS_EN
    // w_wr_en already excludes x0 and reset, so a match here is a real write.
    assign readData1 = (w_wr_en && (writeReg == readReg1)) ? writeData : w_rd1_stored;
    assign readData2 = (w_wr_en && (writeReg == readReg2)) ? writeData : w_rd2_stored;
`else
    assign readData1 = w_rd1_stored;
    assign readData2 = w_rd2_stored;
`endif

    assign wrCount = r_wr_count;

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard testbench for reg_file

module tb_reg_file;

    localparam int XLEN = 32;

    localparam int SEL_RD1 = 0;
    localparam int SEL_RD2 = 1;
    localparam int SEL_DBG = 2;
    localparam int SEL_CNT = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            regWrite;
    logic [4:0]      writeReg;
    logic [XLEN-1:0] writeData;
    logic [4:0]      readReg1;
    logic [4:0]      readReg2;
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;
    logic [4:0]      dbgReg;
    logic [XLEN-1:0] dbgData;
    logic [31:0]     wrCount;

    reg_file #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .dbgReg    (dbgReg),
        .dbgData   (dbgData),
        .wrCount   (wrCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.sel)
                SEL_RD1: act = readData1;
                SEL_RD2: act = readData2;
                SEL_DBG: act = dbgData;
                default: act = wrCount;
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Wait (bounded) until the monitor has consumed all pending expectations.
    task automatic settle();
        for (int k = 0; k < 8; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        regWrite  = 1'b1;
        writeReg  = idx;
        writeData = data;
        tick();
        regWrite  = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;

        // Reset held for two edges with a write pending to x5
        rst       = 1'b1;
        regWrite  = 1'b1;
        writeReg  = 5'd5;
        writeData = 32'hDEAD_BEEF;
        readReg1  = 5'd0;
        readReg2  = 5'd0;
        dbgReg    = 5'd0;
        tick();
        tick();
        rst      = 1'b0;
        regWrite = 1'b0;

        for (int i = 0; i < 32; i++) begin
            dbgReg = 5'(i);
            rv = (i == 2) ? 32'h0000_3FFC : (i == 3) ? 32'h0000_1800 : 32'h0;
            expect_val($sformatf("reset_x%0d", i), SEL_DBG, rv);
            settle();
        end
        readReg1 = 5'd2;
        readReg2 = 5'd3;
        expect_val("reset_rd1_sp", SEL_RD1, 32'h0000_3FFC);
        expect_val("reset_rd2_gp", SEL_RD2, 32'h0000_1800);
        expect_val("reset_wrcount", SEL_CNT, 32'd0);
        settle();

        // Basic write/read
        wr(5'd1,  32'd1);
        wr(5'd31, 32'hFFFF_FFF6);
        readReg1 = 5'd1;
        readReg2 = 5'd31;
        expect_val("basic_rd1_x1", SEL_RD1, 32'd1);
        expect_val("basic_rd2_x31", SEL_RD2, 32'hFFFF_FFF6);
        expect_val("basic_wrcount", SEL_CNT, 32'd2);
        settle();

        // x0 hardwired
        wr(5'd0, 32'h1234_5678);
        readReg1 = 5'd0;
        readReg2 = 5'd0;
        dbgReg   = 5'd0;
        expect_val("x0_rd1", SEL_RD1, 32'd0);
        expect_val("x0_rd2", SEL_RD2, 32'd0);
        expect_val("x0_dbg", SEL_DBG, 32'd0);
        expect_val("x0_wrcount", SEL_CNT, 32'd2);
        settle();

        // Same-cycle read/write on x7: old 5, new 9
        wr(5'd7, 32'd5);
        readReg1  = 5'd7;
        readReg2  = 5'd1;
        dbgReg    = 5'd7;
        regWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'd9;
`ifdef REGFILE_BYPASS_EN
        expect_val("samecyc_rd1_before", SEL_RD1, 32'd9);
`else
        expect_val("samecyc_rd1_before", SEL_RD1, 32'd5);
`endif
        expect_val("samecyc_dbg_before", SEL_DBG, 32'd5);
        expect_val("samecyc_rd2_unrelated", SEL_RD2, 32'd1);
        settle();
        tick();
        regWrite = 1'b0;
        expect_val("samecyc_rd1_after", SEL_RD1, 32'd9);
        expect_val("samecyc_dbg_after", SEL_DBG, 32'd9);
        expect_val("samecyc_wrcount", SEL_CNT, 32'd4);
        settle();

        // Mid-program reset discards the in-flight write
        wr(5'd2,  32'h100);
        wr(5'd10, 32'h55);
        dbgReg = 5'd10;
        expect_val("mid_x10_pre", SEL_DBG, 32'h55);
        expect_val("mid_wrcount_pre", SEL_CNT, 32'd6);
        settle();
        rst       = 1'b1;
        regWrite  = 1'b1;
        writeReg  = 5'd10;
        writeData = 32'h66;
        tick();
        rst      = 1'b0;
        regWrite = 1'b0;
        dbgReg   = 5'd2;
        expect_val("mid_x2", SEL_DBG, 32'h0000_3FFC);
        expect_val("mid_wrcount", SEL_CNT, 32'd0);
        settle();
        dbgReg = 5'd10;
        expect_val("mid_x10", SEL_DBG, 32'd0);
        settle();
        dbgReg = 5'd31;
        expect_val("mid_x31", SEL_DBG, 32'd0);
        settle();

        // wrCount wrap via hierarchical deposit
        dut.r_wr_count = 32'hFFFF_FFFF;
        wr(5'd4, 32'hA5A5_0004);
        dbgReg = 5'd4;
        expect_val("wrap_wrcount", SEL_CNT, 32'd0);
        expect_val("wrap_x4", SEL_DBG, 32'hA5A5_0004);
        settle();
        wr(5'd4, 32'h0000_0044);
        expect_val("wrap_wrcount_next", SEL_CNT, 32'd1);
        expect_val("wrap_x4_next", SEL_DBG, 32'h0000_0044);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

- 32 x 32-bit RISC-V integer register file for the single-cycle core.
- Sits directly upstream of the ALU: its two read ports drive the ALU's rs1 and rs2 operand paths (`aluData1` directly, `aluData2` via the immediate mux).
- Its write port takes the writeback value (ALU result, load data or PC+4).
- Also provides a third, debug-only read port for testbenches and the on-board display.

## Interface
Parameters:
- `XLEN`, 32: register width.
- `SP_INIT`, 32'h0000_3FFC: reset value of x2 (sp).
- `GP_INIT`, 32'h0000_1800: reset value of x3 (gp).

Ports:
- `clk`  input  1  — system clock; all state updates on the rising edge.
- `rst`  input  1  — synchronous reset, active-high.
- `regWrite`  input  1  — write enable from control.
- `writeReg`  input  5  — destination register index (rd).
- `writeData`  input  XLEN  — writeback value.
- `readReg1`  input  5  — rs1 index.
- `readReg2`  input  5  — rs2 index.
- `readData1`  output  XLEN  — rs1 value, to the ALU operand 1.
- `readData2`  output  XLEN  — rs2 value, to the operand-2 mux and store data.
- `dbgReg`  input  5  — debug read index.
- `dbgData`  output  XLEN  — debug read value.
- `wrCount`  output  32  — count of committed writes, for the bench and performance display.

## Operation
- Storage holds 31 registers, x1..x31. x0 is not stored.
  - Any read of index 0 returns 0.
  - Any write to index 0 is discarded and does not increment `wrCount`.
- Write: on a rising edge with `rst`=0, `regWrite`=1 and `writeReg`≠0:
  - reg[`writeReg`] ← `writeData`;
  - `wrCount` ← `wrCount`+1, wrapping 0xFFFF_FFFF → 0.
- Reads on all three ports are combinational from the current register contents.
- Reset: on a rising edge with `rst`=1:
  - all registers ← 0, except x2 ← `SP_INIT` and x3 ← `GP_INIT`;
  - `wrCount` ← 0;
  - any `regWrite` in that cycle is ignored.
- Reset is level-sensitive per edge. Asserting `rst` mid-program discards the in-flight write and restarts contents from the reset values at that edge.
- Inputs with X or Z on `regWrite` are not supported. Control guarantees 0 or 1.

## Timing
- Read latency is 0 cycles (combinational). This matches the single-cycle datapath: decode, read, execute and writeback all complete in one clock.
- A write becomes architecturally visible from the edge that commits it. Reads in the same cycle as the write see the old value unless bypass is compiled in (see Configuration).
- Output values immediately after a reset edge:
  - `readData1`, `readData2` and `dbgData` = 0 for every index except 2 (`SP_INIT`) and 3 (`GP_INIT`);
  - `wrCount` = 0.
- Read ports are independent. `readReg1` = `readReg2` = `dbgReg` all addressing the same register is legal, and all three return the same value.
- No handshake. A write is accepted on every qualifying edge, with no stall or back-pressure.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: write-through forwarding on `readData1` and `readData2`. When `regWrite`=1, `rst`=0, `writeReg`≠0 and `writeReg` equals that port's read index, the port returns `writeData` combinationally in the same cycle.
  - This prepares the block for the planned pipelined core.
  - `dbgData` is never bypassed.
- Not defined: no forwarding. All read ports return stored contents only.
- Default build (single-cycle core) leaves it undefined. A combinational loop through ALU → writeback → bypass would otherwise form.

## Test plan
- Reset values:
  - Stimulus: hold `rst`=1 for 2 edges with `regWrite`=1, `writeReg`=5, `writeData`=32'hDEAD_BEEF. Then read x0..x31 on `dbgData`.
  - Required: x2 = 32'h0000_3FFC, x3 = 32'h0000_1800, all others 0, x5 = 0, `wrCount` = 0.
- Basic write/read:
  - Stimulus: write x1 = 32'd1 and x31 = 32'hFFFF_FFF6, then set `readReg1`=1, `readReg2`=31.
  - Required: `readData1` = 32'd1, `readData2` = 32'hFFFF_FFF6, `wrCount` = 2.
- x0 hardwired:
  - Stimulus: write x0 = 32'h1234_5678, then read index 0 on all three ports.
  - Required: all three return 0, `wrCount` unchanged.
- Same-cycle read/write on x7 (old value 32'd5, new 32'd9):
  - Stimulus: read x7 in the same cycle as the write.
  - Required without `REGFILE_BYPASS_EN`: `readData1` = 5 before the edge, 9 after.
  - Required with `REGFILE_BYPASS_EN`: 9 before the edge, and `dbgData` = 5 before the edge.
- Mid-program reset:
  - Stimulus: write x2 = 32'h100 and x10 = 32'h55, then assert `rst` for 1 edge while writing x10 = 32'h66.
  - Required: x2 = 32'h0000_3FFC, x10 = 0, `wrCount` = 0.
- `wrCount` wrap:
  - Stimulus: force `wrCount` to 32'hFFFF_FFFF via hierarchical deposit, then perform one write to x4.
  - Required: `wrCount` = 0 and x4 updated.
